// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s), paced by a 16x oversampling tick.
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tx_start,
  input  logic                  i_s_tick,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done_tick
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = ($clog2(DATA_WIDTH) > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          state_d = START;
          s_d     = '0;
          b_d     = i_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^i_data;
`endif
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (i_s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so o_tx is registered alongside it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;
  assign o_busy         = (state_q != IDLE);

endmodule
